instr_fetch_unit: RTL and testbench

Fetch sequencer for the highRISC core, sitting on the opposite side of the program counter's control interface. It reads the current PC value, fetches 16-bit words from instruction memory over a request/valid handshake, and resolves branch and jump opcodes locally. It drives the PC's load, offset and step controls and queues ordinary instructions in a small FIFO for the decoder.

---
 rtl/instr_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer for the highRISC core: fetches words at the PC, resolves BRR/JMP locally
// and queues ordinary instructions for the decoder. IFU_HALT_EN adds a HALT opcode and the Halted port.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] PcValue,
    output logic [15:0] LoadValue,
    output logic        LoadEnable,
    output logic [8:0]  Offset,
    output logic        OffsetEnable,
    output logic        StepEnable,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    input  logic        MemValid,
    input  logic [15:0] MemData,
    output logic        InstrValid,
    output logic [15:0] Instr,
    input  logic        InstrReady
`ifdef IFU_HALT_EN
    ,
    output logic        Halted
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [3:0] OP_BRR = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;
`ifdef IFU_HALT_EN
    localparam logic [3:0] OP_HALT = 4'b1111;
`endif

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        JREQ = 2'd1,
        ADV  = 2'd2
    } fetchState_t;

    fetchState_t state, stateNext;
    logic        jumpPending, jumpPendingNext;
    logic        halted, haltedNext;

    logic        memReqNext;
    logic        stepNext, offsetEnNext, loadEnNext;
    logic [8:0]  offsetNext;
    logic [15:0] loadValueNext;

    logic [15:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count, countNext;
    logic             enqueue, dequeue, accept;
    logic [3:0]       opcode;

    assign opcode  = MemData[15:12];
    assign accept  = MemReq & MemValid;
    assign dequeue = InstrValid & InstrReady;

    // The address tracks the PC directly so a PC update is visible on the very next request.
    assign MemAddr    = MemReq ? PcValue : 16'h0000;
    assign InstrValid = (count != '0);
    assign Instr      = InstrValid ? fifoMem[rdPtr] : 16'h0000;
`ifdef IFU_HALT_EN
    assign Halted = halted;
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= REQ;
            jumpPending <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= stateNext;
            jumpPending <= jumpPendingNext;
            halted      <= haltedNext;
        end
    end

    // Next-state, PC control and enqueue decisions
    always_comb begin
        stateNext       = state;
        jumpPendingNext = jumpPending;
        haltedNext      = halted;
        stepNext        = 1'b0;
        offsetEnNext    = 1'b0;
        loadEnNext      = 1'b0;
        offsetNext      = Offset;
        loadValueNext   = LoadValue;
        enqueue         = 1'b0;

        case (state)
            REQ: begin
                if (accept) begin
                    case (opcode)
                        OP_BRR: begin
                            offsetEnNext = 1'b1;
                            offsetNext   = MemData[8:0];
                            stateNext    = ADV;
                        end
                        OP_JMP: begin
                            stepNext        = 1'b1;
                            jumpPendingNext = 1'b1;
                            stateNext       = ADV;
                        end
`ifdef IFU_HALT_EN
                        OP_HALT: begin
                            haltedNext = 1'b1;
                        end
`endif
                        default: begin
                            enqueue   = 1'b1;
                            stepNext  = 1'b1;
                            stateNext = ADV;
                        end
                    endcase
                end
            end
            JREQ: begin
                if (accept) begin
                    loadEnNext    = 1'b1;
                    loadValueNext = MemData;
                    stateNext     = ADV;
                end
            end
            ADV: begin
                jumpPendingNext = 1'b0;
                stateNext       = jumpPending ? JREQ : REQ;
            end
            default: begin
                stateNext = REQ;
            end
        endcase

        countNext = count + CNT_W'(enqueue) - CNT_W'(dequeue);

        // Ordinary fetches wait for queue space; the jump target fetch never does.
        memReqNext = ~haltedNext &
                     (((stateNext == REQ) && (countNext < CNT_W'(FIFO_DEPTH))) ||
                      (stateNext == JREQ));
    end

    // Registered control outputs and queue bookkeeping
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MemReq       <= 1'b0;
            StepEnable   <= 1'b0;
            OffsetEnable <= 1'b0;
            LoadEnable   <= 1'b0;
            Offset       <= 9'h000;
            LoadValue    <= 16'h0000;
            count        <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
        end else begin
            MemReq       <= memReqNext;
            StepEnable   <= stepNext;
            OffsetEnable <= offsetEnNext;
            LoadEnable   <= loadEnNext;
            Offset       <= offsetNext;
            LoadValue    <= loadValueNext;
            count        <= countNext;
            if (enqueue) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (dequeue) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Queue storage; entries are only observable while counted, so no reset is needed
    always_ff @(posedge Clock) begin
        if (enqueue) begin
            fifoMem[wrPtr] <= MemData;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a randomized program
// compared against an instruction-stream model. Honours IFU_HALT_EN when defined.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        Clock;
    logic        Reset;
    logic [15:0] PcValue;
    logic [15:0] LoadValue;
    logic        LoadEnable;
    logic [8:0]  Offset;
    logic        OffsetEnable;
    logic        StepEnable;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemValid;
    logic [15:0] MemData;
    logic        InstrValid;
    logic [15:0] Instr;
    logic        InstrReady;
`ifdef IFU_HALT_EN
    logic        Halted;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] memImg [65536];
    logic [15:0] expQ [$];

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .PcValue      (PcValue),
        .LoadValue    (LoadValue),
        .LoadEnable   (LoadEnable),
        .Offset       (Offset),
        .OffsetEnable (OffsetEnable),
        .StepEnable   (StepEnable),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemValid     (MemValid),
        .MemData      (MemData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrReady   (InstrReady)
`ifdef IFU_HALT_EN
        ,
        .Halted       (Halted)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: the PC model applies this cycle's pulses at the edge; outputs are sampled 2 units later.
    task automatic step();
        logic [15:0] pn;
        pn = PcValue;
        if (StepEnable)   pn = pn + 16'd1;
        if (OffsetEnable) pn = pn + {{7{Offset[8]}}, Offset};
        if (LoadEnable)   pn = LoadValue;
        @(posedge Clock);
        #1;
        PcValue = pn;
        #1;
    endtask

    // Instruction stream the decoder should see when executing memImg from startPc.
    task automatic buildExpected(input logic [15:0] startPc, input int want);
        logic [15:0] pc;
        logic [15:0] w;
        int guard;
        pc = startPc;
        guard = 0;
        expQ.delete();
        while (expQ.size() < want && guard < 200000) begin
            w = memImg[pc];
            guard++;
            if (w[15:12] == 4'hC)      pc = pc + {{7{w[8]}}, w[8:0]};
            else if (w[15:12] == 4'hD) pc = memImg[pc + 16'd1];
            else begin
                expQ.push_back(w);
                pc = pc + 16'd1;
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] reqAddr;
        int u, lat, got, need, cyc;
        bit pending;

        Reset = 1'b1;
        PcValue = 16'h0000;
        MemValid = 1'b0;
        MemData = 16'h0000;
        InstrReady = 1'b0;
        step();
        step();

        // Reset values
        check("rst_memreq", 32'(MemReq), 32'h0);
        check("rst_memaddr", 32'(MemAddr), 32'h0);
        check("rst_enables", 32'({StepEnable, OffsetEnable, LoadEnable}), 32'h0);
        check("rst_loadvalue", 32'(LoadValue), 32'h0);
        check("rst_offset", 32'(Offset), 32'h0);
        check("rst_queue", 32'({InstrValid, Instr}), 32'h0);
`ifdef IFU_HALT_EN
        check("rst_halted", 32'(Halted), 32'h0);
`endif

        // Ordinary fetch of 0x1234 with one cycle of memory latency
        Reset = 1'b0;
        step();
        check("first_req", 32'(MemReq), 32'h1);
        check("first_addr", 32'(MemAddr), 32'h0);
        step();
        check("req_held", 32'(MemReq), 32'h1);
        MemValid = 1'b1; MemData = 16'h1234;
        step();
        MemValid = 1'b0;
        check("ord_step", 32'(StepEnable), 32'h1);
        check("ord_queue", 32'({InstrValid, Instr}), 32'h11234);
        check("ord_adv_noreq", 32'(MemReq), 32'h0);
        step();
        check("ord_step_len", 32'(StepEnable), 32'h0);
        check("ord_next_req", 32'(MemReq), 32'h1);
        check("ord_next_addr", 32'(MemAddr), 32'h0001);

        // BRR 0xC0FE, zero-wait
        MemValid = 1'b1; MemData = 16'hC0FE;
        step();
        MemValid = 1'b0;
        check("brr_pulses", 32'({StepEnable, OffsetEnable, LoadEnable}), 32'h2);
        check("brr_offset", 32'(Offset), 32'h0FE);
        check("brr_queue", 32'({InstrValid, Instr}), 32'h11234);
        step();
        check("brr_pulse_len", 32'(OffsetEnable), 32'h0);
        check("brr_target_addr", 32'(MemAddr), 32'h00FF);

        // JMP at 0x0010 with target word 0x0400 at 0x0011
        PcValue = 16'h0010;
        #1;
        check("jmp_addr", 32'(MemAddr), 32'h0010);
        MemValid = 1'b1; MemData = 16'hD000;
        step();
        MemValid = 1'b0;
        check("jmp_pulses", 32'({StepEnable, OffsetEnable, LoadEnable}), 32'h4);
        check("jmp_noenq", 32'({InstrValid, Instr}), 32'h11234);
        step();
        check("jreq_req", 32'(MemReq), 32'h1);
        check("jreq_addr", 32'(MemAddr), 32'h0011);
        MemValid = 1'b1; MemData = 16'h0400;
        step();
        MemValid = 1'b0;
        check("jmp_load_pulses", 32'({StepEnable, OffsetEnable, LoadEnable}), 32'h1);
        check("jmp_loadvalue", 32'(LoadValue), 32'h0400);
        check("jmp_target_noenq", 32'({InstrValid, Instr}), 32'h11234);
        step();
        check("jmp_target_fetch", 32'({MemReq, MemAddr}), 32'h10400);
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("drain_empty", 32'(InstrValid), 32'h0);

        // Fill the queue with InstrReady low
        for (int i = 0; i < 4; i++) begin
            check("fill_req", 32'(MemReq), 32'h1);
            MemValid = 1'b1; MemData = 16'h1000 + 16'(i);
            step();
            MemValid = 1'b0;
            step();
        end
        check("full_noreq", 32'(MemReq), 32'h0);
        step();
        step();
        check("full_hold", 32'(MemReq), 32'h0);
        check("full_head", 32'(Instr), 32'h1000);
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("full_reassert", 32'(MemReq), 32'h1);
        check("full_new_head", 32'(Instr), 32'h1001);

        // Reset in the middle of a request with two entries queued
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("mid_req", 32'({MemReq, Instr}), 32'h11002);
        Reset = 1'b1;
        #1;
        check("async_memreq", 32'(MemReq), 32'h0);
        check("async_addr", 32'(MemAddr), 32'h0);
        check("async_queue", 32'({InstrValid, Instr}), 32'h0);
        PcValue = 16'h0200;
        step();
        Reset = 1'b0;
        step();
        check("post_rst_fetch", 32'({MemReq, MemAddr}), 32'h10200);
        check("post_rst_empty", 32'(InstrValid), 32'h0);

        // Opcode 0xF after one ordinary word
        MemValid = 1'b1; MemData = 16'h2222;
        step();
        MemValid = 1'b0;
        step();
        MemValid = 1'b1; MemData = 16'hF000;
        step();
        MemValid = 1'b0;
`ifdef IFU_HALT_EN
        check("halt_flag", 32'(Halted), 32'h1);
        check("halt_nopulse", 32'({StepEnable, OffsetEnable, LoadEnable}), 32'h0);
        check("halt_noreq", 32'(MemReq), 32'h0);
        check("halt_noenq", 32'({InstrValid, Instr}), 32'h12222);
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("halt_drains", 32'(InstrValid), 32'h0);
        step();
        step();
        check("halt_stays", 32'({Halted, MemReq}), 32'h2);
`else
        check("f_step", 32'(StepEnable), 32'h1);
        check("f_queue_head", 32'({InstrValid, Instr}), 32'h12222);
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("f_enqueued", 32'({InstrValid, Instr}), 32'h1F000);
`endif

        // Randomized program against the instruction-stream model
        Reset = 1'b1;
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            u = $urandom_range(0, 15);
            if (u == 0)      w[15:12] = 4'hC;
            else if (u == 1) w[15:12] = 4'hD;
            else if (w[15:12] == 4'hC || w[15:12] == 4'hD) w[15:12] = 4'h1;
`ifdef IFU_HALT_EN
            if (w[15:12] == 4'hF) w[15:12] = 4'h2;
`endif
            memImg[a] = w;
        end
        PcValue = 16'($urandom);
        buildExpected(PcValue, 150);
        need = expQ.size();
        step();
        Reset = 1'b0;
        step();
        got = 0;
        cyc = 0;
        pending = 1'b0;
        lat = 0;
        reqAddr = 16'h0000;
        while (got < need && cyc < 8000) begin
            if ({StepEnable, OffsetEnable, LoadEnable} != 3'b000)
                check("rnd_onehot", 32'($countones({StepEnable, OffsetEnable, LoadEnable})), 32'h1);
            MemValid = 1'b0;
            MemData = 16'($urandom);
            if (MemReq) begin
                if (!pending) begin
                    pending = 1'b1;
                    lat = $urandom_range(0, 2);
                    reqAddr = MemAddr;
                end else begin
                    check("rnd_addr_stable", 32'(MemAddr), 32'(reqAddr));
                end
                if (lat == 0) begin
                    MemValid = 1'b1;
                    MemData = memImg[MemAddr];
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                MemValid = 1'b1;
            end
            InstrReady = 1'($urandom_range(0, 1));
            if (InstrValid && InstrReady) begin
                if (expQ.size() == 0) check("rnd_underrun", 32'h1, 32'h0);
                else check("rnd_instr", 32'(Instr), 32'(expQ.pop_front()));
                got++;
            end
            step();
            cyc++;
        end
        MemValid = 1'b0;
        InstrReady = 1'b0;
        check("rnd_stream_len", 32'(got), 32'(need));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
